// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, image geometry and the registered VGA output bundle
// used by the VRAM scan controller.
package vga_timing_pkg;

  localparam int CLK_DIV   = 4;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int H_SYNC_START = H_VISIBLE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int V_SYNC_START = V_VISIBLE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int IMG_W  = 128;
  localparam int IMG_H  = 96;
  localparam int SCALE  = 5;
  localparam int ADDR_W = 14;
  localparam int COL_W  = 7;
  localparam int ROW_W  = 7;
  localparam int CNT_W  = 10;

  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic       hsync;
    logic       vsync;
  } vga_out_t;

  localparam vga_out_t VGA_OUT_RESET = '{red: 4'h0, green: 4'h0, blue: 4'h0,
                                          hsync: 1'b1, vsync: 1'b1};

endpackage

// File: rtl/pixel_tick_gen.sv
// Divides the system clock down to a one-clk pixel enable; tick is high while the
// divider sits at CLK_DIV-1, so the first tick lands on the CLK_DIV-th edge after reset.
module pixel_tick_gen #(
  parameter int CLK_DIV = vga_timing_pkg::CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    div_d = tick ? '0 : div_q + DIV_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= div_d;
  end

endmodule

// File: rtl/vram_scan_controller.sv
// Raster timing master: walks the 128x96 image 5x upscaled across a 640x480 screen, drives
// the shared VRAM address and registers the returned plane bits together with the syncs.
module vram_scan_controller #(
  parameter int CLK_DIV   = vga_timing_pkg::CLK_DIV,
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_FP      = vga_timing_pkg::H_FP,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BP      = vga_timing_pkg::H_BP,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FP      = vga_timing_pkg::V_FP,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BP      = vga_timing_pkg::V_BP,
  parameter int SCALE     = vga_timing_pkg::SCALE
) (
  input  logic        clk,
  input  logic        reset,
  output logic [13:0] vram_addr,
  input  logic        red_bit,
  input  logic        green_bit,
  input  logic        blue_bit,
  output logic [3:0]  vga_red,
  output logic [3:0]  vga_green,
  output logic [3:0]  vga_blue,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        frame_start
);

  import vga_timing_pkg::*;

  localparam int HT    = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int VT    = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS0   = H_VISIBLE + H_FP;
  localparam int HS1   = HS0 + H_SYNC;
  localparam int VS0   = V_VISIBLE + V_FP;
  localparam int VS1   = VS0 + V_SYNC;
  localparam int SUB_W = $clog2(SCALE + 1);

  logic                 tick;
  logic [CNT_W-1:0]     hcount_q, hcount_d, vcount_q, vcount_d;
  logic [SUB_W-1:0]     hsub_q, hsub_d, vsub_q, vsub_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [ROW_W-1:0]     row_q, row_d;
  vga_out_t             out_q, out_d;
  logic                 h_end, v_end, h_vis, v_vis, de;

  pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (reset),
    .tick  (tick)
  );

  assign h_end = (hcount_q == CNT_W'(HT - 1));
  assign v_end = (vcount_q == CNT_W'(VT - 1));
  assign h_vis = (hcount_q < CNT_W'(H_VISIBLE));
  assign v_vis = (vcount_q < CNT_W'(V_VISIBLE));
  assign de    = h_vis && v_vis;

  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    hsub_d   = hsub_q;
    vsub_d   = vsub_q;
    col_d    = col_q;
    row_d    = row_q;
    out_d    = out_q;
    if (tick) begin
      // The output stage samples the counters as they stand before this tick moves them,
      // so colour and sync share one pixel period of latency.
      out_d.red   = de ? {4{red_bit}}   : 4'h0;
      out_d.green = de ? {4{green_bit}} : 4'h0;
      out_d.blue  = de ? {4{blue_bit}}  : 4'h0;
      out_d.hsync = !((hcount_q >= CNT_W'(HS0)) && (hcount_q < CNT_W'(HS1)));
      out_d.vsync = !((vcount_q >= CNT_W'(VS0)) && (vcount_q < CNT_W'(VS1)));

      hcount_d = h_end ? '0 : hcount_q + CNT_W'(1);
      if (h_vis) begin
        if (hsub_q == SUB_W'(SCALE - 1)) begin
          hsub_d = '0;
          col_d  = col_q + COL_W'(1);
        end else begin
          hsub_d = hsub_q + SUB_W'(1);
        end
      end
      if (h_end) begin
        vcount_d = v_end ? '0 : vcount_q + CNT_W'(1);
        hsub_d   = '0;
        col_d    = '0;
        if (v_vis) begin
          if (vsub_q == SUB_W'(SCALE - 1)) begin
            vsub_d = '0;
            row_d  = row_q + ROW_W'(1);
          end else begin
            vsub_d = vsub_q + SUB_W'(1);
          end
        end
        if (v_end) begin
          vsub_d = '0;
          row_d  = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcount_q <= '0;
      vcount_q <= '0;
      hsub_q   <= '0;
      vsub_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      out_q    <= VGA_OUT_RESET;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hsub_q   <= hsub_d;
      vsub_q   <= vsub_d;
      col_q    <= col_d;
      row_q    <= row_d;
      out_q    <= out_d;
    end
  end

  // Address comes straight from the counter flops so the BRAM sees a glitch-free value
  // for the whole pixel period.
  assign vram_addr   = {row_q, col_q};
  assign vga_red     = out_q.red;
  assign vga_green   = out_q.green;
  assign vga_blue    = out_q.blue;
  assign vga_hsync   = out_q.hsync;
  assign vga_vsync   = out_q.vsync;
  assign frame_start = tick && h_end && v_end;

endmodule

// File: tb/tb_vram_scan_controller.sv
// Bench for vram_scan_controller: a full-size instance and a shrunken-timing instance,
// both reading random image planes, checked per clock against a raster reference model.
module tb_vram_scan_controller;
  import vga_timing_pkg::*;

  // Full-size instance A
  localparam int A_DIV = CLK_DIV;
  localparam int A_HT  = H_TOTAL;
  localparam int A_VT  = V_TOTAL;
  // Shrunken instance B so whole frames fit in a short run
  localparam int B_DIV = 2;
  localparam int B_HV  = 20;
  localparam int B_HFP = 2;
  localparam int B_HS  = 3;
  localparam int B_HBP = 2;
  localparam int B_VV  = 15;
  localparam int B_VFP = 1;
  localparam int B_VS  = 2;
  localparam int B_VBP = 2;
  localparam int B_HT  = B_HV + B_HFP + B_HS + B_HBP;
  localparam int B_VT  = B_VV + B_VFP + B_VS + B_VBP;

  localparam int W = 29;
  localparam logic [W-1:0] RST_ENTRY = {1'b1, 14'd0, 12'd0, 1'b1, 1'b1};

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bit img_r [0:IMG_W*IMG_H-1];
  bit img_g [0:IMG_W*IMG_H-1];
  bit img_b [0:IMG_W*IMG_H-1];

  logic [13:0] a_addr, b_addr;
  logic        a_rb = 1'b0, a_gb = 1'b0, a_bb = 1'b0;
  logic        b_rb = 1'b0, b_gb = 1'b0, b_bb = 1'b0;
  logic [3:0]  a_red, a_green, a_blue, b_red, b_green, b_blue;
  logic        a_hs, a_vs, a_fs, b_hs, b_vs, b_fs;

  vram_scan_controller dut_a (
    .clk(clk), .reset(rst_n), .vram_addr(a_addr),
    .red_bit(a_rb), .green_bit(a_gb), .blue_bit(a_bb),
    .vga_red(a_red), .vga_green(a_green), .vga_blue(a_blue),
    .vga_hsync(a_hs), .vga_vsync(a_vs), .frame_start(a_fs)
  );

  vram_scan_controller #(
    .CLK_DIV(B_DIV), .H_VISIBLE(B_HV), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
    .V_VISIBLE(B_VV), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP), .SCALE(SCALE)
  ) dut_b (
    .clk(clk), .reset(rst_n), .vram_addr(b_addr),
    .red_bit(b_rb), .green_bit(b_gb), .blue_bit(b_bb),
    .vga_red(b_red), .vga_green(b_green), .vga_blue(b_blue),
    .vga_hsync(b_hs), .vga_vsync(b_vs), .frame_start(b_fs)
  );

  // BRAM models: one clock of read latency
  always @(posedge clk) begin
    a_rb <= img_r[a_addr];
    a_gb <= img_g[a_addr];
    a_bb <= img_b[a_addr];
    b_rb <= img_r[b_addr];
    b_gb <= img_g[b_addr];
    b_bb <= img_b[b_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: pixel index p counts ticks since reset; screen position is p mod line/frame.
  // Entry n holds the address expected after tick n and the outputs for pixel n-1.
  function automatic logic [W-1:0] exp_entry(input int n, input int ht, input int vt,
                                             input int hv, input int vv, input int hs0,
                                             input int hs1, input int vs0, input int vs1);
    int h, v, idx;
    logic chk, hs, vs;
    logic [13:0] a;
    logic [3:0] r, g, b;
    h = n % ht;
    v = (n / ht) % vt;
    chk = (h < hv) && (v < vv);
    a = chk ? 14'((v / SCALE) * IMG_W + h / SCALE) : 14'd0;
    h = (n - 1) % ht;
    v = ((n - 1) / ht) % vt;
    r = 4'h0; g = 4'h0; b = 4'h0;
    if ((h < hv) && (v < vv)) begin
      idx = (v / SCALE) * IMG_W + h / SCALE;
      r = {4{img_r[idx]}};
      g = {4{img_g[idx]}};
      b = {4{img_b[idx]}};
    end
    hs = !((h >= hs0) && (h < hs1));
    vs = !((v >= vs0) && (v < vs1));
    return {chk, a, r, g, b, hs, vs};
  endfunction

  function automatic logic exp_fs(input logic rn, input int cnt, input int div, input int ft);
    int n;
    if (!rn || ((cnt + 1) % div != 0)) return 1'b0;
    n = (cnt + 1) / div;
    return ((n - 1) % ft) == (ft - 1);
  endfunction

  task automatic compare_out(input string tag, input logic [W-1:0] e, input logic [13:0] addr,
                             input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                             input logic hs, input logic vs);
    if (e[28]) check({tag, "_addr"}, addr, e[27:14]);
    check({tag, "_red"}, r, e[13:10]);
    check({tag, "_green"}, g, e[9:6]);
    check({tag, "_blue"}, b, e[5:2]);
    check({tag, "_hsync"}, hs, e[1]);
    check({tag, "_vsync"}, vs, e[0]);
  endtask

  // scoreboard: model pushes expected per tick, monitor pops and compares every clock
  int a_cnt = 0, b_cnt = 0;
  logic [W-1:0] a_exp_q[$];
  logic [W-1:0] b_exp_q[$];
  logic [W-1:0] a_cur = RST_ENTRY;
  logic [W-1:0] b_cur = RST_ENTRY;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cnt = 0; b_cnt = 0;
      a_exp_q.delete(); b_exp_q.delete();
    end else begin
      a_cnt++; b_cnt++;
      if (a_cnt % A_DIV == 0)
        a_exp_q.push_back(exp_entry(a_cnt / A_DIV, A_HT, A_VT, H_VISIBLE, V_VISIBLE,
                                    H_SYNC_START, H_SYNC_END, V_SYNC_START, V_SYNC_END));
      if (b_cnt % B_DIV == 0)
        b_exp_q.push_back(exp_entry(b_cnt / B_DIV, B_HT, B_VT, B_HV, B_VV,
                                    B_HV + B_HFP, B_HV + B_HFP + B_HS,
                                    B_VV + B_VFP, B_VV + B_VFP + B_VS));
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      a_cur = RST_ENTRY;
      b_cur = RST_ENTRY;
    end else begin
      if (a_exp_q.size() > 0) a_cur = a_exp_q.pop_front();
      if (b_exp_q.size() > 0) b_cur = b_exp_q.pop_front();
    end
    compare_out("a", a_cur, a_addr, a_red, a_green, a_blue, a_hs, a_vs);
    compare_out("b", b_cur, b_addr, b_red, b_green, b_blue, b_hs, b_vs);
    check("a_frame_start", a_fs, exp_fs(rst_n, a_cnt, A_DIV, A_HT * A_VT));
    check("b_frame_start", b_fs, exp_fs(rst_n, b_cnt, B_DIV, B_HT * B_VT));
  end

  // stimulus
  initial begin
    for (int i = 0; i < IMG_W * IMG_H; i++) begin
      img_r[i] = 1'($urandom_range(0, 1));
      img_g[i] = 1'($urandom_range(0, 1));
      img_b[i] = 1'($urandom_range(0, 1));
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    // six full-size lines: address rows 0 and 1, hsync timing; many small frames
    repeat (20000) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    compare_out("a_async", RST_ENTRY, a_addr, a_red, a_green, a_blue, a_hs, a_vs);
    compare_out("b_async", RST_ENTRY, b_addr, b_red, b_green, b_blue, b_hs, b_vs);
    check("a_async_fs", a_fs, 1'b0);
    check("b_async_fs", b_fs, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3000) @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
